// File: rtl/cm0_irq_pkg.sv
// Shared definitions for the Cortex-M0 interrupt expander: register map and AHB-Lite encodings.
package cm0_irq_pkg;

  typedef enum logic [1:0] {
    REG_ENABLE  = 2'd0,
    REG_MODE    = 2'd1,
    REG_PENDING = 2'd2,
    REG_RAW     = 2'd3
  } reg_sel_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

endpackage

// File: rtl/cm0_irq_sync.sv
// Multi-bit, multi-stage synchroniser; every stage clears to 0 on reset.
module cm0_irq_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain_q [STAGES];

  // NOTE: the chain is a handful of flops, not a RAM, so it is safe and required to reset it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) chain_q[s] <= '0;
    end else begin
      chain_q[0] <= d;
      for (int s = 1; s < STAGES; s++) chain_q[s] <= chain_q[s-1];
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/cm0_irq_expander.sv
// Interrupt front-end: synchronises NUM_SRC sources, applies enable/level/edge config and
// folds them onto the core IRQ lines; configured through a zero-wait-state AHB-Lite slave.
module cm0_irq_expander
  import cm0_irq_pkg::*;
#(
  parameter int NUM_SRC     = 32,
  parameter int NUM_IRQ     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               HSEL,
  input  logic [31:0]        HADDR,
  input  logic [1:0]         HTRANS,
  input  logic               HWRITE,
  input  logic [2:0]         HSIZE,
  input  logic [31:0]        HWDATA,
  input  logic               HREADY,
  output logic               HREADYOUT,
  output logic               HRESP,
  output logic [31:0]        HRDATA,
  input  logic [NUM_SRC-1:0] SRC,
  output logic [15:0]        IRQ
);

  logic               dp_valid, dp_write, dp_word;
  reg_sel_e           dp_sel;
  logic [NUM_SRC-1:0] enable_q, mode_q, pending_q, prev_q;
  logic [NUM_SRC-1:0] sync_q, edge_det, w1c, act, wdata;
  logic [15:0]        irq_nxt;
  logic               addr_accept, wr_en;
  logic               unused_ok;

  cm0_irq_sync #(.WIDTH(NUM_SRC), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .d     (SRC),
    .q     (sync_q)
  );

  assign addr_accept = HSEL & HTRANS[1] & HREADY;
  assign wr_en       = dp_valid & dp_write & dp_word;
  assign wdata       = HWDATA[NUM_SRC-1:0];
  assign edge_det    = sync_q & ~prev_q;
  assign w1c         = (wr_en && dp_sel == REG_PENDING) ? wdata : '0;
  assign act         = (mode_q & pending_q) | (~mode_q & sync_q);

  always_comb begin
    // NOTE: default first so no path through the loop can leave a bit unassigned (no latch).
    irq_nxt = '0;
    for (int i = 0; i < NUM_SRC; i++) irq_nxt[i % NUM_IRQ] = irq_nxt[i % NUM_IRQ] | (enable_q[i] & act[i]);
  end

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid  <= 1'b0;
      dp_write  <= 1'b0;
      dp_word   <= 1'b0;
      dp_sel    <= REG_ENABLE;
      enable_q  <= '0;
      mode_q    <= '0;
      pending_q <= '0;
      prev_q    <= '0;
      IRQ       <= '0;
    end else begin
      dp_valid <= addr_accept;
      dp_write <= HWRITE;
      dp_word  <= (HSIZE == HSIZE_WORD);
      dp_sel   <= reg_sel_e'(HADDR[3:2]);
      prev_q   <= sync_q;
      IRQ      <= irq_nxt;
      if (wr_en && dp_sel == REG_ENABLE) enable_q <= wdata;
      if (wr_en && dp_sel == REG_MODE)   mode_q   <= wdata;
      // A new edge wins over a W1C landing on the same edge; level-mode bits never hold.
      pending_q <= ((pending_q & ~w1c) | (edge_det & mode_q)) & mode_q;
    end
  end

  always_comb begin
    HRDATA = '0;
    if (dp_valid && !dp_write) begin
      unique case (dp_sel)
        REG_ENABLE:  HRDATA = 32'(enable_q);
        REG_MODE:    HRDATA = 32'(mode_q);
        REG_PENDING: HRDATA = 32'(pending_q & mode_q);
        REG_RAW:     HRDATA = 32'(sync_q);
      endcase
    end
  end

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign unused_ok = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA};

endmodule
